// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for an 8-digit common-anode
//             seven-segment display. Each digit slot starts with a dead-time
//             blank, then drives one anode through a PWM brightness gate,
//             a per-digit enable and a hex-to-segment decoder. Display
//             content is captured once per frame so partial updates of the
//             value registers never reach the pins.
//  Options  : define SEG_LZB_EN to enable leading-zero blanking (zero digits
//             above the most significant non-zero digit are kept dark;
//             digit 0 is always shown).
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
   parameter int SLOT_CYCLES  = 12500,
   parameter int BLANK_CYCLES = 250
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] digits,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  digit_en,
   input  logic [3:0]  brightness,
   output logic [7:0]  anode,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_tick
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_cw = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

   // Last count of a slot, and last count of the dead-time blank.
   localparam logic [c_cw-1:0] c_slot_last  = c_cw'(SLOT_CYCLES - 1);
   localparam logic [c_cw-1:0] c_blank_last = c_cw'(BLANK_CYCLES - 1);

   localparam logic [7:0] c_anode_off = 8'hFF;
   localparam logic [6:0] c_seg_off   = 7'h7F;

   typedef enum logic [0:0] {
      S_BLANK = 1'b0,
      S_ON    = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Scan timing state
   // ------------------------------------------------------------------------
   state_t          r_state;
   logic [2:0]      r_idx;
   logic [c_cw-1:0] r_cnt;
   logic [3:0]      r_pwm;

   // Per-frame snapshot of the display content.
   logic [31:0]     r_nib_s;
   logic [7:0]      r_dp_s;
   logic [7:0]      r_en_s;
   logic [3:0]      r_bright_s;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic            w_snap;
   logic            w_gate;
   logic            w_drive;
   logic [3:0]      w_nib;
   logic [7:0]      w_anode_sel;
   logic [7:0]      w_blank;
   logic [7:0]      w_en_eff;
   logic [7:0]      w_dp_eff;

   // First blank cycle of digit 0 marks the frame start.
   assign w_snap      = (r_state == S_BLANK) && (r_idx == 3'd0) && (r_cnt == '0);

   // Full brightness bypasses the comparator so that 15 lights every cycle.
   assign w_gate      = (r_bright_s == 4'hF) || (r_pwm < r_bright_s);

   assign w_drive     = (r_state == S_ON) && r_en_s[r_idx] && w_gate;
   assign w_nib       = r_nib_s[{r_idx, 2'b00} +: 4];
   assign w_anode_sel = ~(8'h01 << r_idx);

`ifdef SEG_LZB_EN
   // w_zero_from[k] is high when digit k and every digit above it are zero.
   logic [7:1] w_zero_from;

   assign w_zero_from[7] = (digits[31:28] == 4'h0);

   for (genvar k = 1; k < 7; k++) begin : g_lzb
      assign w_zero_from[k] = (digits[4*k +: 4] == 4'h0) && w_zero_from[k+1];
   end

   // Digit 0 is never a leading zero.
   assign w_blank = {w_zero_from, 1'b0};
`else
   assign w_blank = 8'h00;
`endif

   // Blanked digits lose both their segments and their decimal point.
   assign w_en_eff = digit_en & ~w_blank;
   assign w_dp_eff = dp_in & ~w_blank;

   // ------------------------------------------------------------------------
   // Hex to active-low segment pattern {g,f,e,d,c,b,a}
   // ------------------------------------------------------------------------
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Slot counter, digit index, blank/on state machine and PWM counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_BLANK;
         r_idx   <= 3'd0;
         r_cnt   <= '0;
         r_pwm   <= 4'd0;
      end else begin
         if (r_cnt == c_slot_last) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         case (r_state)
            S_BLANK: begin
               r_pwm <= 4'd0;
               if (r_cnt == c_blank_last) begin
                  r_state <= S_ON;
               end
            end
            S_ON: begin
               r_pwm <= r_pwm + 4'd1;
               if (r_cnt == c_slot_last) begin
                  r_state <= S_BLANK;
               end
            end
            default: begin
               r_state <= S_BLANK;
               r_pwm   <= 4'd0;
            end
         endcase
      end
   end

   // Capture display content once per frame; reset leaves every digit dark.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_nib_s    <= 32'h0;
         r_dp_s     <= 8'h00;
         r_en_s     <= 8'h00;
         r_bright_s <= 4'h0;
      end else if (w_snap) begin
         r_nib_s    <= digits;
         r_dp_s     <= w_dp_eff;
         r_en_s     <= w_en_eff;
         r_bright_s <= brightness;
      end
   end

   // Registered pin drivers, one cycle behind the scan state.
   always_ff @(posedge clk) begin
      if (reset) begin
         anode      <= c_anode_off;
         seg        <= c_seg_off;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= w_snap;
         if (w_drive) begin
            anode <= w_anode_sel;
            seg   <= hex_to_seg(w_nib);
            dp    <= ~r_dp_s[r_idx];
         end else begin
            anode <= c_anode_off;
            seg   <= c_seg_off;
            dp    <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Purpose  : Self-checking bench for seg_scan_ctrl with SLOT_CYCLES=16 and
//             BLANK_CYCLES=4. A cycle model predicts every output cycle
//             into a queue; per-frame table vectors and a few hand-written
//             sequences check aggregate behaviour. Define SEG_LZB_EN to
//             match an RTL build with leading-zero blanking.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

   localparam int SLOT  = 16;
   localparam int BLANK = 4;
   localparam int FRAME = 8 * SLOT;
`ifdef SEG_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] digits = 32'h0;
   logic [7:0]  dp_in = 8'h00;
   logic [7:0]  digit_en = 8'h00;
   logic [3:0]  brightness = 4'h0;
   logic [7:0]  anode;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_tick;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .SLOT_CYCLES  (SLOT),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .digits     (digits),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .brightness (brightness),
      .anode      (anode),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   typedef struct packed {
      logic [7:0] anode;
      logic [6:0] seg;
      logic       dp;
      logic       tick;
   } out_t;

   out_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: cycle index since reset release and the frame snapshot.
   int          u = 0;
   logic [31:0] m_digits = 32'h0;
   logic [7:0]  m_en = 8'h00;
   logic [7:0]  m_dp = 8'h00;
   logic [3:0]  m_br = 4'h0;

   // Observation statistics.
   int         lit_cnt[8];
   logic [7:0] seen_mask;
   logic [6:0] seg_obs[8];
   logic       dp0_obs;
   int         tick_cnt;
   int         first_digit;
   int         seg_bad;
   logic [6:0] seg_want = 7'h7F;
   bit         want_valid = 1'b0;
   int         multi_low = 0;
   int         gap_err = 0;
   int         gap = 100;
   int         last_d = -1;

   function automatic logic [6:0] ref_seg(input logic [3:0] v);
      case (v)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   function automatic logic [7:0] ref_blank(input logic [31:0] d);
      logic [7:0] b;
      bit zero_above;
      b = 8'h00;
      zero_above = 1'b1;
      for (int k = 7; k >= 1; k--) begin
         zero_above = zero_above && (d[4*k +: 4] == 4'h0);
         b[k] = LZB && zero_above;
      end
      return b;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_stats();
      for (int k = 0; k < 8; k++) begin
         lit_cnt[k] = 0;
         seg_obs[k] = 7'h7F;
      end
      seen_mask   = 8'h00;
      dp0_obs     = 1'b1;
      tick_cnt    = 0;
      first_digit = -1;
      seg_bad     = 0;
   endtask

   // One clock: predict, advance, then compare and gather statistics.
   task automatic tick();
      out_t e;
      out_t a;
      int   idx;
      int   c;
      int   d;
      bit   lit;
      if (reset) begin
         e.anode = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.tick = 1'b0;
         u = 0;
      end else begin
         if (u % FRAME == 0) begin
            m_digits = digits;
            m_en     = digit_en & ~ref_blank(digits);
            m_dp     = dp_in & ~ref_blank(digits);
            m_br     = brightness;
         end
         idx = (u / SLOT) % 8;
         c   = u % SLOT;
         lit = (c >= BLANK) && m_en[idx] && ((m_br == 4'hF) || ((c - BLANK) < int'(m_br)));
         e.tick = (u % FRAME == 0);
         if (lit) begin
            e.anode = ~(8'h01 << idx);
            e.seg   = ref_seg(m_digits[4*idx +: 4]);
            e.dp    = ~m_dp[idx];
         end else begin
            e.anode = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
         end
         u++;
      end
      exp_q.push_back(e);

      @(posedge clk);
      #1;

      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         a = {anode, seg, dp, frame_tick};
         chk("scoreboard_out{anode,seg,dp,tick}", 64'(a), 64'(e));
      end

      tick_cnt += int'(frame_tick);
      if (anode !== 8'hFF) begin
         d = -1;
         for (int k = 7; k >= 0; k--) if (anode[k] == 1'b0) d = k;
         if ($countones(~anode) != 1) multi_low++;
         if (d >= 0) begin
            if (last_d >= 0 && d != last_d && gap < BLANK) gap_err++;
            last_d = d;
            lit_cnt[d]++;
            seen_mask[d] = 1'b1;
            seg_obs[d] = seg;
            if (d == 0) dp0_obs = dp;
            if (first_digit < 0) first_digit = d;
            if (want_valid && seg !== seg_want) seg_bad++;
         end
         gap = 0;
      end else begin
         gap++;
      end
   endtask

   typedef struct {
      logic [31:0] digits;
      logic [7:0]  dp;
      logic [7:0]  en;
      logic [3:0]  br;
      logic [7:0]  exp_mask;
      int          exp_lit;
      logic [6:0]  exp_seg0;
      logic [6:0]  exp_seg7;
      logic        exp_dp0;
   } vec_t;

   vec_t vt[7];

   initial begin
      vt[0] = '{32'h76543210, 8'h00, 8'hFF, 4'hF, 8'hFF, 12, 7'b1000000, 7'b1111000, 1'b1};
      vt[1] = '{32'h76543210, 8'h00, 8'hFF, 4'h4, 8'hFF,  4, 7'b1000000, 7'b1111000, 1'b1};
      vt[2] = '{32'h76543210, 8'h00, 8'hFF, 4'h0, 8'h00,  0, 7'b1000000, 7'b1111000, 1'b1};
      vt[3] = '{32'h76543210, 8'h00, 8'h05, 4'hF, 8'h05, 12, 7'b1000000, 7'b1111000, 1'b1};
      vt[4] = '{32'hFFFFFFFF, 8'h01, 8'hFF, 4'hF, 8'hFF, 12, 7'b0001110, 7'b0001110, 1'b0};
      vt[5] = '{32'h00000120, 8'hFF, 8'hFF, 4'hF, (LZB ? 8'h07 : 8'hFF), 12,
                7'b1000000, 7'b1000000, 1'b0};
      vt[6] = '{32'h00000000, 8'h00, 8'hFF, 4'hF, (LZB ? 8'h01 : 8'hFF), 12,
                7'b1000000, 7'b1000000, 1'b1};

      clear_stats();

      // Reset: outputs checked by the scoreboard on each reset cycle.
      reset = 1'b1;
      repeat (3) tick();
      chk("reset_anode", 64'(anode), 64'hFF);
      chk("reset_seg", 64'(seg), 64'h7F);
      chk("reset_dp_tick", 64'({dp, frame_tick}), 64'b10);
      reset = 1'b0;

      // Table vectors, one frame each, inputs applied at the frame start.
      for (int i = 0; i < 7; i++) begin
         digits     = vt[i].digits;
         dp_in      = vt[i].dp;
         digit_en   = vt[i].en;
         brightness = vt[i].br;
         clear_stats();
         repeat (FRAME) tick();
         chk($sformatf("vec%0d_mask", i), 64'(seen_mask), 64'(vt[i].exp_mask));
         for (int k = 0; k < 8; k++)
            chk($sformatf("vec%0d_lit_d%0d", i, k), 64'(lit_cnt[k]),
                64'(vt[i].exp_mask[k] ? vt[i].exp_lit : 0));
         if (vt[i].exp_mask[0]) begin
            chk($sformatf("vec%0d_seg0", i), 64'(seg_obs[0]), 64'(vt[i].exp_seg0));
            chk($sformatf("vec%0d_dp0", i), 64'(dp0_obs), 64'(vt[i].exp_dp0));
         end
         if (vt[i].exp_mask[7])
            chk($sformatf("vec%0d_seg7", i), 64'(seg_obs[7]), 64'(vt[i].exp_seg7));
         chk($sformatf("vec%0d_ticks", i), 64'(tick_cnt), 64'd1);
      end

      // Mid-frame content change must wait for the next frame.
      digits = 32'h0; dp_in = 8'h00; digit_en = 8'hFF; brightness = 4'hF;
      clear_stats();
      seg_want = 7'b1000000; want_valid = 1'b1;
      repeat (40) tick();
      digits = 32'hFFFFFFFF;
      repeat (FRAME - 40) tick();
      chk("midframe_old_seg_bad", 64'(seg_bad), 64'd0);
      chk("midframe_old_mask", 64'(seen_mask), 64'(LZB ? 8'h01 : 8'hFF));
      clear_stats();
      seg_want = 7'b0001110;
      repeat (FRAME) tick();
      chk("midframe_new_seg_bad", 64'(seg_bad), 64'd0);
      chk("midframe_new_mask", 64'(seen_mask), 64'hFF);
      want_valid = 1'b0;

      // Reset while digit 5 is lit, then scanning restarts at digit 0.
      digits = 32'h76543210; dp_in = 8'h00; digit_en = 8'hFF; brightness = 4'hF;
      repeat (5 * SLOT + 8) tick();
      chk("pre_reset_digit5_lit", 64'(anode), 64'hDF);
      reset = 1'b1;
      tick();
      chk("midreset_outputs", 64'({anode, seg, dp, frame_tick}), 64'({8'hFF, 7'h7F, 1'b1, 1'b0}));
      reset = 1'b0;
      clear_stats();
      repeat (FRAME) tick();
      chk("post_reset_first_digit", 64'(first_digit), 64'd0);
      chk("post_reset_mask", 64'(seen_mask), 64'hFF);
      chk("post_reset_ticks", 64'(tick_cnt), 64'd1);

      // Dead-time invariants gathered over the whole run.
      chk("one_anode_at_most", 64'(multi_low), 64'd0);
      chk("dead_time_gap", 64'(gap_err), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit, common-anode seven-segment display on the Nexys4 board. It generates the digit-select sequence itself and lights one digit at a time. Each digit slot has a dead-time blank, a PWM brightness gate, a per-digit enable mask and hex-to-segment decode. It sits between the application value registers and the top-level anode/cathode pins. Display content is latched once per frame so a partially updated value is never shown.

Parameters:
SLOT_CYCLES, 12500, clk cycles per digit slot (100 MHz / 12500 = 8 kHz slot rate, 1 kHz frame rate).
BLANK_CYCLES, 250, dead-time cycles at the start of each slot with all anodes off; legal range 1 .. SLOT_CYCLES-1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
digits  in  32  eight hex nibbles; digit k = digits[4k+3:4k]
dp_in  in  8  decimal point per digit, 1 = lit
digit_en  in  8  per-digit enable, 0 = digit dark for its whole slot
brightness  in  4  0 = off, 15 = full on
anode  out  8  active-low digit select; bit k = digit k
seg  out  7  active-low cathodes {g,f,e,d,c,b,a}; bit0 = a
dp  out  1  active-low decimal point
frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: anode=8'hFF, seg=7'h7F, dp=1, frame_tick=0. Internally: state=S_BLANK, idx=0, slot counter=0, pwm counter=0, snapshot registers=0 (all digits disabled).
- Slot counter: width $clog2(SLOT_CYCLES), counts 0..SLOT_CYCLES-1, then wraps to 0. On wrap, idx increments modulo 8 (7 -> 0).
- FSM states:
  - S_BLANK while counter < BLANK_CYCLES.
  - S_ON while counter >= BLANK_CYCLES.
  - S_BLANK -> S_ON when counter = BLANK_CYCLES-1.
  - S_ON -> S_BLANK on counter wrap.
- Snapshot: digits, dp_in, digit_en and brightness are registered on the first S_BLANK cycle of idx 0. This includes the first cycle after reset deasserts. Input changes at any other time have no effect until the next frame.
- frame_tick: high for exactly that same snapshot cycle.
- PWM: a 4-bit counter increments every cycle in S_ON and clears in S_BLANK. gate = (bright_s == 15) || (pwm < bright_s). bright_s = 0 gives no lit cycles.
- Drive condition for digit idx: S_ON && en_s[idx] && gate. When true, anode has only bit idx low, seg = decode(nibble_s[idx]) and dp = ~dp_s[idx]. Otherwise anode=8'hFF, seg=7'h7F, dp=1.
- Latency: all outputs are registered, one cycle after the internal state they reflect.
- Decode (gfedcba, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Disabled digit: its slot is still consumed, so frame rate is constant regardless of the enable mask.
- Dead time: at most one anode is low in any cycle. All anodes are high for at least BLANK_CYCLES cycles between two different digits.
- Reset mid-slot: returns to reset values on the next edge. Scanning restarts at idx 0 with a fresh snapshot.

Optional Feature:
SEG_LZB_EN: leading-zero blanking.
- Defined: at snapshot, every digit k >= 1 whose nibble is 0 and whose higher digits k+1..7 are all 0 has its effective enable forced to 0. The dp of a blanked digit is also suppressed. Digit 0 is never blanked by this rule. The computation is registered with the snapshot and adds no latency to outputs.
- Undefined: zero nibbles display as "0"; only digit_en controls blanking.

Test Plan:
- Parameters for all scenarios: SLOT_CYCLES=16, BLANK_CYCLES=4.
1. Reset, then digits=32'h76543210, digit_en=8'hFF, brightness=15 -> per slot: 4 cycles anode=FF, then 12 cycles anode=~(1<<idx); idx 0 shows seg=7'b1000000, idx 7 shows 7'b1111000; frame_tick every 128 cycles.
2. brightness=4, digit 0 -> in each 16-cycle PWM window, 4 lit cycles (pwm 0..3) and 12 dark; brightness=0 -> anode stays FF for the whole frame.
3. digit_en=8'b0000_0101 -> only digits 0 and 2 are ever driven low; frame period is still 128 cycles.
4. Change digits from 32'h0 to 32'hFFFFFFFF mid-frame -> current frame stays "0" on every digit; the next frame after frame_tick shows seg=7'b0001110.
5. Assert reset during the S_ON phase of digit 5 -> next edge anode=FF, seg=7F, dp=1; after release scanning resumes at digit 0.
6. With SEG_LZB_EN: digits=32'h00000120, digit_en=FF -> digits 0..2 are driven, digits 3..7 stay dark; digits=0 -> only digit 0 is driven, showing "0".
